cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_capture_if.sv | 29 ++
 rtl/rgb565_to_gray.sv | 25 ++
 rtl/cam_capture.sv | 183 ++++++++++++++++++
 tb/tb_cam_capture.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types, defaults and gray-conversion constants for the camera capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    CAPTURE   = 2'd2
  } cam_state_t;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  localparam int GRAY_COEF_R = 77;
  localparam int GRAY_COEF_G = 150;
  localparam int GRAY_COEF_B = 29;

  // Widen 5/6-bit colour fields to 8 bits by replicating their MSBs into the low bits.
  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera byte bus and SDRAM write-FIFO handshake grouped for the capture block.
interface cam_capture_if;

  logic        cam_vsync_i;
  logic        cam_href_i;
  logic [7:0]  cam_data_i;
  logic        sdram_fifo_full;
  logic        wr_en;
  logic [15:0] data_o;

  modport master (
    output cam_vsync_i,
    output cam_href_i,
    output cam_data_i,
    output sdram_fifo_full,
    input  wr_en,
    input  data_o
  );

  modport slave (
    input  cam_vsync_i,
    input  cam_href_i,
    input  cam_data_i,
    input  sdram_fifo_full,
    output wr_en,
    output data_o
  );

endinterface

// File: rtl/rgb565_to_gray.sv
// Combinational RGB565 to 8-bit luma: weighted 16-bit sum of expanded channels, truncated.
module rgb565_to_gray
  import cam_pkg::*;
(
  input  logic [15:0] i_rgb,
  output logic [7:0]  o_gray
);

  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic [15:0] w_sum;

  assign w_r8 = expand5(i_rgb[15:11]);
  assign w_g8 = expand6(i_rgb[10:5]);
  assign w_b8 = expand5(i_rgb[4:0]);

  // Coefficients sum to 256, so the full-scale result fits the 16-bit accumulator.
  assign w_sum = 16'(GRAY_COEF_R) * {8'h00, w_r8}
               + 16'(GRAY_COEF_G) * {8'h00, w_g8}
               + 16'(GRAY_COEF_B) * {8'h00, w_b8};

  assign o_gray = w_sum[15:8];

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture: assembles byte pairs into RGB565 (or gray) words and
// streams them into an SDRAM write FIFO, framed by VSYNC/HREF.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          continuous_i,
  input  logic          sobel_i,
  cam_capture_if.slave  bus,
  output logic          frame_done_o,
  output logic          overflow_o,
  output logic          frame_err_o
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(H_ACTIVE);
  localparam logic [LW-1:0] LINE_MAX = LW'(V_ACTIVE);

  cam_state_t  r_state;
  cam_state_t  w_nextState;
  logic        w_enterCapture;

  logic        r_vsync;
  logic        r_vsyncPrev;
  logic        r_href;
  logic        r_hrefPrev;
  logic [7:0]  r_data;

  logic        r_phase;
  logic [7:0]  r_hiByte;
  logic [CW-1:0] r_colCount;
  logic [LW-1:0] r_lineCount;
  logic        r_sobel;

  logic        r_wrEn;
  logic [15:0] r_dataOut;
  logic        r_frameDone;
  logic        r_overflow;
  logic        r_frameErr;

  logic        w_vsyncRise;
  logic        w_vsyncFall;
  logic        w_hrefRise;
  logic        w_hrefFall;
  logic        w_capturing;
  logic        w_phaseEff;
  logic        w_inRange;
  logic        w_lineEnd;
  logic        w_vsyncEnd;
  logic        w_frameEnd;
  logic        w_frameErr;
  logic [15:0] w_pixel;
  logic [7:0]  w_gray;

  assign w_vsyncRise = r_vsync & ~r_vsyncPrev;
  assign w_vsyncFall = ~r_vsync & r_vsyncPrev;
  assign w_hrefRise  = r_href & ~r_hrefPrev;
  assign w_hrefFall  = ~r_href & r_hrefPrev;
  assign w_capturing = (r_state == CAPTURE);

  // The first byte of a line is always a high byte, even if the previous line ended odd.
  assign w_phaseEff = w_hrefRise ? 1'b0 : r_phase;
  assign w_inRange  = (r_colCount < COL_MAX);

  assign w_lineEnd  = w_capturing & w_hrefFall & (r_lineCount == LINE_MAX - LW'(1));
  assign w_vsyncEnd = w_capturing & w_vsyncRise;
  assign w_frameEnd = w_lineEnd | w_vsyncEnd;
  assign w_frameErr = w_vsyncEnd & ~w_lineEnd;

  assign w_pixel = {r_hiByte, r_data};

  rgb565_to_gray u_gray (
    .i_rgb  (w_pixel),
    .o_gray (w_gray)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_enterCapture = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_nextState = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (w_vsyncFall) begin
          w_nextState    = CAPTURE;
          w_enterCapture = 1'b1;
        end
      end
      CAPTURE: begin
        if (w_frameEnd) begin
          w_nextState = continuous_i ? WAIT_SYNC : IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Stage-1 camera sampling, pixel assembly, FIFO write and sticky status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vsync     <= 1'b0;
      r_vsyncPrev <= 1'b0;
      r_href      <= 1'b0;
      r_hrefPrev  <= 1'b0;
      r_data      <= 8'h00;
      r_phase     <= 1'b0;
      r_hiByte    <= 8'h00;
      r_colCount  <= '0;
      r_lineCount <= '0;
      r_sobel     <= 1'b0;
      r_wrEn      <= 1'b0;
      r_dataOut   <= 16'h0000;
      r_frameDone <= 1'b0;
      r_overflow  <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_vsync     <= bus.cam_vsync_i;
      r_vsyncPrev <= r_vsync;
      r_href      <= bus.cam_href_i;
      r_hrefPrev  <= r_href;
      r_data      <= bus.cam_data_i;
      r_wrEn      <= 1'b0;
      r_frameDone <= w_frameEnd;

      if (w_enterCapture) begin
        r_colCount  <= '0;
        r_lineCount <= '0;
        r_phase     <= 1'b0;
        r_sobel     <= sobel_i;
      end else if (w_capturing) begin
        if (w_hrefRise) begin
          r_colCount <= '0;
        end
        if (r_href) begin
          r_phase <= ~w_phaseEff;
          if (!w_phaseEff) begin
            r_hiByte <= r_data;
          end else if (w_inRange) begin
            r_colCount <= r_colCount + CW'(1);
            if (bus.sdram_fifo_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_wrEn    <= 1'b1;
              r_dataOut <= r_sobel ? {8'h00, w_gray} : w_pixel;
            end
          end
        end
        if (w_hrefFall && (r_lineCount != LINE_MAX)) begin
          r_lineCount <= r_lineCount + LW'(1);
        end
        if (w_frameErr) begin
          r_frameErr <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_en     = r_wrEn;
  assign bus.data_o    = r_dataOut;
  assign frame_done_o  = r_frameDone;
  assign overflow_o    = r_overflow;
  assign frame_err_o   = r_frameErr;

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: transaction-level model predicts every
// write and frame_done cycle; directed frames pin counts and gray values.
module tb_cam_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cont;
  logic sobel;
  logic frameDone;
  logic overflow;
  logic frameErr;

  cam_capture_if bus ();

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .continuous_i (cont),
    .sobel_i      (sobel),
    .bus          (bus),
    .frame_done_o (frameDone),
    .overflow_o   (overflow),
    .frame_err_o  (frameErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } wr_t;

  wr_t         wrQ[$];
  int          doneQ[$];
  logic [15:0] wrLog[$];
  int          wrCount   = 0;
  int          doneCount = 0;
  int          nChecks   = 0;
  int          nFails    = 0;

  bit mCapturing = 0;
  bit mArmed     = 0;
  bit mSobel     = 0;
  bit mOverflow  = 0;
  bit mErr       = 0;
  int mLines     = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Luma from plain integer arithmetic on the colour fields.
  function automatic logic [7:0] modelGray(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8, sum;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    sum = (77 * r8 + 150 * g8 + 29 * b8) % 65536;
    return 8'(sum / 256);
  endfunction

  always @(negedge clk) begin
    if (wrQ.size() > 0 && wrQ[0].cyc == cyc) begin
      checkOutput("wr_en pulse", bus.wr_en, 1);
      checkOutput("data_o", bus.data_o, wrQ[0].data);
      void'(wrQ.pop_front());
    end else begin
      checkOutput("wr_en quiet", bus.wr_en, 0);
    end
    if (doneQ.size() > 0 && doneQ[0] == cyc) begin
      checkOutput("frame_done pulse", frameDone, 1);
      void'(doneQ.pop_front());
    end else begin
      checkOutput("frame_done quiet", frameDone, 0);
    end
    if (bus.wr_en === 1'b1) begin
      wrCount++;
      wrLog.push_back(bus.data_o);
    end
    if (frameDone === 1'b1) doneCount++;
  end

  task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d, input logic f);
    @(posedge clk);
    #2;
    bus.cam_vsync_i     = v;
    bus.cam_href_i      = h;
    bus.cam_data_i      = d;
    bus.sdram_fifo_full = f;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0);
  endtask

  task automatic modelReset(input int p);
    wr_t keepW[$];
    int  keepD[$];
    foreach (wrQ[i]) if (wrQ[i].cyc <= p) keepW.push_back(wrQ[i]);
    foreach (doneQ[i]) if (doneQ[i] <= p) keepD.push_back(doneQ[i]);
    wrQ        = keepW;
    doneQ      = keepD;
    mCapturing = 0;
    mArmed     = 0;
    mOverflow  = 0;
    mErr       = 0;
    mLines     = 0;
  endtask

  task automatic pulseStart();
    applyStimulus(0, 0, 8'h00, 0);
    start = 1'b1;
    if (!mCapturing) mArmed = 1;
    applyStimulus(0, 0, 8'h00, 0);
    start = 1'b0;
    idleCycles(2);
  endtask

  task automatic vsyncPulse();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(k < 3, 0, 8'h00, 0);
      if (k == 0 && mCapturing) begin
        doneQ.push_back(cyc + 2);
        if (mLines != V) mErr = 1;
        mCapturing = 0;
        mArmed     = cont;
      end
      if (k == 3 && mArmed && !mCapturing) begin
        mCapturing = 1;
        mArmed     = 0;
        mLines     = 0;
        mSobel     = sobel;
      end
    end
  endtask

  // Pixel i alternates pixA/pixB; dropMask bit i holds the FIFO full around pixel i.
  task automatic sendLine(input int nPix, input logic [15:0] pixA, input logic [15:0] pixB,
                          input bit oddByte, input logic [15:0] dropMask, input int rstAt);
    int nBytes = 2 * nPix + (oddByte ? 1 : 0);
    for (int k = 0; k < nBytes + 4; k++) begin
      int          i = k / 2;
      logic [15:0] word = (i % 2 == 1) ? pixB : pixA;
      logic [7:0]  d = 8'h00;
      logic        f = 1'b0;
      if (k < 2 * nPix) d = (k % 2 == 0) ? word[15:8] : word[7:0];
      else if (k < nBytes) d = 8'hA5;
      for (int j = 0; j < 16; j++)
        if (dropMask[j] && k >= 2 * j + 1 && k <= 2 * j + 3) f = 1'b1;
      applyStimulus(0, k < nBytes, d, f);
      if (k == rstAt) begin
        rst = 1'b1;
        modelReset(cyc);
      end else if (rst) begin
        rst = 1'b0;
        checkOutput("reset wr_en", bus.wr_en, 0);
        checkOutput("reset data_o", bus.data_o, 16'h0000);
        checkOutput("reset frame_done", frameDone, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset frame_err", frameErr, 0);
      end
      if (mCapturing && k < 2 * nPix && k % 2 == 1 && i < H) begin
        if (dropMask[i]) mOverflow = 1;
        else wrQ.push_back('{cyc + 2, mSobel ? {8'h00, modelGray(word)} : word});
      end
      if (mCapturing && k == nBytes) begin
        mLines++;
        if (mLines == V) begin
          doneQ.push_back(cyc + 2);
          mCapturing = 0;
          mArmed     = cont;
        end
      end
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, " overflow"}, overflow, mOverflow);
    checkOutput({tag, " frame_err"}, frameErr, mErr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int baseW, baseD, baseL;
    logic [15:0] first, second;
    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    sobel = 1'b0;
    bus.cam_vsync_i     = 1'b0;
    bus.cam_href_i      = 1'b0;
    bus.cam_data_i      = 8'h00;
    bus.sdram_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    checkOutput("init wr_en", bus.wr_en, 0);
    checkOutput("init data_o", bus.data_o, 16'h0000);
    checkOutput("init frame_done", frameDone, 0);
    checkOutput("init overflow", overflow, 0);
    checkOutput("init frame_err", frameErr, 0);

    $display("[TB] basic RGB565 frame");
    pulseStart();
    vsyncPulse();
    baseW = wrCount; baseD = doneCount;
    sendLine(4, 16'hF800, 16'hF800, 0, 16'h0000, -1);
    sendLine(4, 16'hF800, 16'hF800, 0, 16'h0000, -1);
    idleCycles(4);
    checkOutput("rgb frame writes", wrCount - baseW, 8);
    checkOutput("rgb frame done count", doneCount - baseD, 1);
    checkOutput("rgb frame overflow", overflow, 0);
    checkOutput("rgb frame frame_err", frameErr, 0);

    $display("[TB] gray frame, sobel_i dropped mid-frame");
    sobel = 1'b1;
    pulseStart();
    vsyncPulse();
    baseW = wrCount; baseL = wrLog.size();
    sendLine(4, 16'hFFFF, 16'hF800, 0, 16'h0000, -1);
    sobel = 1'b0;
    sendLine(4, 16'hFFFF, 16'hF800, 0, 16'h0000, -1);
    idleCycles(4);
    checkOutput("gray frame writes", wrCount - baseW, 8);
    first  = (wrLog.size() > baseL)     ? wrLog[baseL]     : 16'hDEAD;
    second = (wrLog.size() > baseL + 1) ? wrLog[baseL + 1] : 16'hDEAD;
    checkOutput("gray of FFFF", first, 16'h00FF);
    checkOutput("gray of F800", second, 16'h004C);

    $display("[TB] FIFO full on third pixel");
    pulseStart();
    vsyncPulse();
    baseW = wrCount;
    sendLine(4, 16'h07E0, 16'h001F, 0, 16'h0004, -1);
    sendLine(4, 16'h07E0, 16'h001F, 0, 16'h0000, -1);
    idleCycles(4);
    checkOutput("overflow frame writes", wrCount - baseW, 7);
    checkOutput("overflow set", overflow, 1);
    checkFlags("overflow frame");

    $display("[TB] VSYNC ends frame early, continuous re-arm");
    cont = 1'b1;
    pulseStart();
    vsyncPulse();
    sendLine(4, 16'h1234, 16'h5678, 0, 16'h0000, -1);
    baseD = doneCount;
    vsyncPulse();
    checkOutput("early end done count", doneCount - baseD, 1);
    checkOutput("early end frame_err", frameErr, 1);
    cont = 1'b0;
    baseW = wrCount;
    sendLine(4, 16'h1234, 16'h5678, 0, 16'h0000, -1);
    sendLine(4, 16'h1234, 16'h5678, 0, 16'h0000, -1);
    idleCycles(4);
    checkOutput("re-armed frame writes", wrCount - baseW, 8);
    checkFlags("re-armed frame");

    $display("[TB] long line with odd trailing byte");
    pulseStart();
    vsyncPulse();
    baseW = wrCount;
    sendLine(6, 16'h1234, 16'hABCD, 1, 16'h0000, -1);
    checkOutput("long line writes", wrCount - baseW, 4);
    sendLine(4, 16'hC0DE, 16'h4321, 0, 16'h0000, -1);
    idleCycles(4);
    checkOutput("sticky overflow held", overflow, 1);
    checkOutput("sticky frame_err held", frameErr, 1);

    $display("[TB] reset mid-line");
    pulseStart();
    vsyncPulse();
    sendLine(4, 16'hF800, 16'h07E0, 0, 16'h0000, 3);
    idleCycles(2);
    checkFlags("after reset");
    baseW = wrCount;
    sendLine(4, 16'hF800, 16'h07E0, 0, 16'h0000, -1);
    vsyncPulse();
    pulseStart();
    sendLine(4, 16'hF800, 16'h07E0, 0, 16'h0000, -1);
    idleCycles(4);
    checkOutput("no writes before fresh VSYNC", wrCount - baseW, 0);
    vsyncPulse();
    sendLine(4, 16'hF800, 16'h07E0, 0, 16'h0000, -1);
    sendLine(4, 16'hF800, 16'h07E0, 0, 16'h0000, -1);
    idleCycles(6);
    checkOutput("writes after re-arm", wrCount - baseW, 8);

    checkOutput("write queue drained", wrQ.size(), 0);
    checkOutput("done queue drained", doneQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
